// File: rtl/counter_log_pkg.sv
// Shared constants for the counter event logger.
// Entry layout: {hit2, hit1, count2, count1, timestamp}.
package counter_log_pkg;
    localparam int TS_W      = 14;
    localparam int LOG_DEPTH = 16;
    localparam int ENTRY_W   = 32;
    localparam int HIT2_BIT  = 31;
    localparam int HIT1_BIT  = 30;
    localparam int C2_LSB    = 22;
    localparam int C1_LSB    = 14;
    localparam int TS_LSB    = 0;
endpackage

// File: rtl/log_fifo.sv
// First-word-fall-through FIFO with flush.
// Read data reads as zero while empty.
module log_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [AW:0]      level_o,
    output logic             empty_o,
    output logic             full_o
);
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_rd;
    logic             do_wr;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;
    assign do_rd   = rd_en_i & ~empty_o;
    // a pop frees the slot, so a write into a full FIFO is allowed then
    assign do_wr   = wr_en_i & (~full_o | do_rd);
    assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    // next pointer values; flush empties the FIFO
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_wr) wptr_d = wptr_q + 1'b1;
            if (do_rd) rptr_d = rptr_q + 1'b1;
        end
    end

    // pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // storage array, no reset needed since empty masks the output
    always_ff @(posedge clk_i) begin
        if (do_wr && !flush_i) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/counter_event_log.sv
// Logs rising-edge matches of two counters into a FIFO,
// each entry stamped with both counts and a timestamp.
module counter_event_log
    import counter_log_pkg::*;
#(
    parameter int DEPTH = LOG_DEPTH,
    parameter int TS_W  = 14
) (
    input  logic                   sys_clk,
    input  logic                   reset_n,
    input  logic [7:0]             count1,
    input  logic [7:0]             count2,
    input  logic [7:0]             match1,
    input  logic [7:0]             match2,
    input  logic                   arm,
    input  logic                   clear,
    input  logic                   pop,
    output logic [ENTRY_W-1:0]     log_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   not_empty,
    output logic                   overflow,
    output logic                   ev_pulse,
    output logic                   ovf_pulse
);
    logic            eq1, eq2;
    logic            eq1_q, eq2_q;
    logic            hit1, hit2, any_hit;
    logic            fifo_empty, fifo_full;
    logic            ev_d, ovf_d;
    logic            ev_q, ovf_q, overflow_q, overflow_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [ENTRY_W-1:0] entry_d;

    assign eq1     = (count1 == match1);
    assign eq2     = (count2 == match2);
    assign hit1    = eq1 & ~eq1_q & arm;
    assign hit2    = eq2 & ~eq2_q & arm;
    assign any_hit = (hit1 | hit2) & ~clear;

    // entry assembly from the current counts and timestamp
    always_comb begin
        entry_d = '0;
        entry_d[HIT2_BIT]       = hit2;
        entry_d[HIT1_BIT]       = hit1;
        entry_d[C2_LSB +: 8]    = count2;
        entry_d[C1_LSB +: 8]    = count1;
        entry_d[TS_LSB +: TS_W] = ts_q;
    end

    // write vs drop decision and the timestamp/overflow next state
    always_comb begin
        ev_d       = any_hit & (~fifo_full | pop);
        ovf_d      = any_hit & fifo_full & ~pop;
        overflow_d = overflow_q | ovf_d;
        ts_d       = ts_q + TS_W'(1);
        if (clear) begin
            overflow_d = 1'b0;
            ts_d       = '0;
        end
    end

    // equality history, timestamp, sticky overflow and pulses
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            eq1_q      <= 1'b0;
            eq2_q      <= 1'b0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            ev_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            eq1_q      <= eq1;
            eq2_q      <= eq2;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            ev_q       <= ev_d;
            ovf_q      <= ovf_d;
        end
    end

    log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (sys_clk),
        .rst_ni    (reset_n),
        .flush_i   (clear),
        .wr_en_i   (any_hit),
        .wr_data_i (entry_d),
        .rd_en_i   (pop),
        .rd_data_o (log_data),
        .level_o   (level),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    assign not_empty = ~fifo_empty;
    assign overflow  = overflow_q;
    assign ev_pulse  = ev_q;
    assign ovf_pulse = ovf_q;
endmodule

// File: tb/tb_counter_event_log.sv
// Directed bench for counter_event_log with a queue-based
// reference model compared every cycle.
module tb_counter_event_log;
    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  count1 = '0, count2 = '0;
    logic [7:0]  match1 = '0, match2 = '0;
    logic        arm = 1'b0, clear = 1'b0, pop = 1'b0;
    logic [31:0] log_data;
    logic [4:0]  level;
    logic        not_empty, overflow, ev_pulse, ovf_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ev     = 0;
    int n_ovp    = 0;

    logic [31:0] mq[$];
    bit          m_ovf, m_ev, m_ovp, m_p1, m_p2;
    int          m_ts;

    counter_event_log dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .count1    (count1),
        .count2    (count2),
        .match1    (match1),
        .match2    (match2),
        .arm       (arm),
        .clear     (clear),
        .pop       (pop),
        .log_data  (log_data),
        .level     (level),
        .not_empty (not_empty),
        .overflow  (overflow),
        .ev_pulse  (ev_pulse),
        .ovf_pulse (ovf_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // reference model: queue of entries, sticky flag, modulo timestamp
    initial begin
        forever begin
            @(posedge sys_clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                m_ovf = 0; m_ev = 0; m_ovp = 0;
                m_p1 = 0; m_p2 = 0; m_ts = 0;
            end else begin
                bit e1, e2, h1, h2;
                logic [31:0] ent;
                e1 = (count1 == match1);
                e2 = (count2 == match2);
                h1 = e1 && !m_p1 && arm;
                h2 = e2 && !m_p2 && arm;
                m_p1 = e1; m_p2 = e2;
                m_ev = 0; m_ovp = 0;
                ent = {h2, h1, count2, count1, 14'(m_ts)};
                if (clear) begin
                    mq.delete();
                    m_ovf = 0;
                    m_ts = 0;
                end else begin
                    if (pop && mq.size() > 0) void'(mq.pop_front());
                    if (h1 || h2) begin
                        if (mq.size() < 16) begin
                            mq.push_back(ent);
                            m_ev = 1;
                        end else begin
                            m_ovf = 1;
                            m_ovp = 1;
                        end
                    end
                    m_ts = (m_ts + 1) % 16384;
                end
            end
        end
    end

    // every-cycle comparison against the model, plus pulse counters
    initial begin
        forever begin
            @(negedge sys_clk);
            chk("log_data", log_data, mq.size() ? mq[0] : 32'h0);
            chk("level", 32'(level), 32'(mq.size()));
            chk("not_empty", 32'(not_empty), 32'(mq.size() != 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("ev_pulse", 32'(ev_pulse), 32'(m_ev));
            chk("ovf_pulse", 32'(ovf_pulse), 32'(m_ovp));
            if (ev_pulse) n_ev++;
            if (ovf_pulse) n_ovp++;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic hit_c1();
        count1 = match1;
        step();
        count1 = 8'h00;
        step();
    endtask

    initial begin
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // disarmed: matches never log
        match1 = 8'h22; match2 = 8'h33;
        for (int i = 0; i < 6; i++) begin
            count1 = 8'(8'h20 + i);
            count2 = 8'(8'h30 + i);
            step();
        end
        chk("disarmed_level", 32'(level), 32'd0);

        // single hit at timestamp 10
        count1 = 8'h00; count2 = 8'h00;
        arm = 1'b1; match1 = 8'h05; match2 = 8'hAA;
        do_clear();
        repeat (10) step();
        n_ev = 0;
        count1 = 8'h05;
        repeat (20) step();
        chk("single_entry", log_data, 32'h4001400A);
        chk("single_level", 32'(level), 32'd1);
        chk("single_ev_cnt", 32'(n_ev), 32'd1);

        // asynchronous reset with no clock edge
        #2 reset_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_data", log_data, 32'h0);
        chk("arst_ne", 32'(not_empty), 32'd0);
        @(posedge sys_clk);
        #1 reset_n = 1'b1;
        count1 = 8'h00;
        step();

        // simultaneous hits share one entry
        match1 = 8'h80; match2 = 8'h80;
        do_clear();
        repeat (3) step();
        count1 = 8'h80; count2 = 8'h80;
        step();
        chk("simul_entry", log_data, 32'hE0200003);
        chk("simul_level", 32'(level), 32'd1);
        count1 = 8'h00; count2 = 8'h00;
        step();

        // overflow on the 17th hit
        match1 = 8'h10; match2 = 8'hFF;
        do_clear();
        n_ovp = 0;
        for (int i = 0; i < 17; i++) hit_c1();
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_pulse_cnt", 32'(n_ovp), 32'd1);
        for (int i = 0; i < 16; i++) begin
            pop = 1'b1;
            step();
        end
        pop = 1'b0;
        step();
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_ne", 32'(not_empty), 32'd0);
        chk("drain_data", log_data, 32'h0);
        chk("drain_ovf", 32'(overflow), 32'd1);
        do_clear();
        chk("clr_ovf", 32'(overflow), 32'd0);

        // full with pop and hit together
        for (int i = 0; i < 16; i++) hit_c1();
        count1 = 8'h10; pop = 1'b1;
        step();
        count1 = 8'h00; pop = 1'b0;
        chk("fullpop_level", 32'(level), 32'd16);
        chk("fullpop_ovf", 32'(overflow), 32'd0);
        chk("fullpop_ev", 32'(ev_pulse), 32'd1);
        step();

        // clear wins over a coincident hit
        count1 = 8'h10; clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clrhit_level", 32'(level), 32'd0);
        chk("clrhit_ev", 32'(ev_pulse), 32'd0);
        chk("clrhit_ovp", 32'(ovf_pulse), 32'd0);
        count1 = 8'h00;
        step();

        // timestamp wraps back to zero
        do_clear();
        repeat (16384) step();
        count1 = 8'h10;
        step();
        chk("wrap_entry", log_data, 32'h40040000);
        count1 = 8'h00;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
